sync_trace_fifo: RTL and testbench

SYNC_TRACE_FIFO -- requirements
Module: sync_trace_fifo

---
 rtl/sync_trace_fifo.sv | 133 +++++++++++++
 tb/tb_sync_trace_fifo.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_trace_fifo.sv
// Single-clock trace FIFO with occupancy count, programmable thresholds and
// either first-word-fall-through or registered read data.
module sync_trace_fifo #(
    parameter int                 DEPTH             = 16,
    parameter int                 WIDTH             = 32,
    parameter int                 FWFT              = 1,
    parameter int                 PROG_FULL_THRESH  = DEPTH - 2,
    parameter int                 PROG_EMPTY_THRESH = 2,
    parameter logic [WIDTH-1:0]   DOUT_RESET_VALUE  = {WIDTH{1'b0}},
    localparam int                CW                = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             write,
    output logic             full,
    output logic [WIDTH-1:0] dout,
    input  logic             read,
    output logic             empty,
    output logic [CW-1:0]    data_count,
    output logic             prog_full,
    output logic             prog_empty,
    output logic             overflow,
    output logic             underflow
);

    localparam int          AW     = $clog2(DEPTH);
    localparam logic [31:0] PF_LVL = PROG_FULL_THRESH;
    localparam logic [31:0] PE_LVL = PROG_EMPTY_THRESH;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW-1:0]    wr_ptr_nxt_s;
    logic [AW-1:0]    rd_ptr_nxt_s;
    logic [CW-1:0]    count_r;
    logic [CW-1:0]    count_nxt_s;
    logic [31:0]      count_ext_s;
    logic             full_s;
    logic             empty_s;
    logic             wr_en_s;
    logic             rd_en_s;
    logic             overflow_r;
    logic             underflow_r;

    // Wrap at DEPTH-1 explicitly so non-power-of-two depths work.
    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        if (p == AW'(DEPTH - 1)) begin
            return {AW{1'b0}};
        end else begin
            return p + AW'(1);
        end
    endfunction

    assign full_s      = (count_r == CW'(DEPTH));
    assign empty_s     = (count_r == {CW{1'b0}});
    // rst_n gating keeps the un-reset memory from capturing writes during reset.
    assign wr_en_s     = write & ~full_s & rst_n;
    assign rd_en_s     = read & ~empty_s;
    assign count_ext_s = {{(32 - CW){1'b0}}, count_r};

    assign full       = full_s;
    assign empty      = empty_s;
    assign data_count = count_r;
    assign prog_full  = (count_ext_s >= PF_LVL);
    assign prog_empty = (count_ext_s <= PE_LVL);
    assign overflow   = overflow_r;
    assign underflow  = underflow_r;

    // Next pointer and occupancy from the accepted operations.
    always_comb begin
        wr_ptr_nxt_s = wr_ptr_r;
        rd_ptr_nxt_s = rd_ptr_r;
        count_nxt_s  = count_r;
        if (wr_en_s) begin
            wr_ptr_nxt_s = ptr_inc(wr_ptr_r);
        end else begin
            wr_ptr_nxt_s = wr_ptr_r;
        end
        if (rd_en_s) begin
            rd_ptr_nxt_s = ptr_inc(rd_ptr_r);
        end else begin
            rd_ptr_nxt_s = rd_ptr_r;
        end
        case ({wr_en_s, rd_en_s})
            2'b10:   count_nxt_s = count_r + CW'(1);
            2'b01:   count_nxt_s = count_r - CW'(1);
            default: count_nxt_s = count_r;
        endcase
    end

    // Control state and rejected-operation pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r    <= {AW{1'b0}};
            rd_ptr_r    <= {AW{1'b0}};
            count_r     <= {CW{1'b0}};
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            wr_ptr_r    <= wr_ptr_nxt_s;
            rd_ptr_r    <= rd_ptr_nxt_s;
            count_r     <= count_nxt_s;
            overflow_r  <= write & full_s;
            underflow_r <= read & empty_s;
        end
    end

    // Storage array, intentionally without reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    if (FWFT != 0) begin : g_fwft
        assign dout = empty_s ? DOUT_RESET_VALUE : mem_r[rd_ptr_r];
    end else begin : g_std
        logic [WIDTH-1:0] dout_r;

        // Registered read data, held unless a read is accepted.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                dout_r <= DOUT_RESET_VALUE;
            end else if (rd_en_s) begin
                dout_r <= mem_r[rd_ptr_r];
            end
        end

        assign dout = dout_r;
    end

endmodule

// File: tb/tb_sync_trace_fifo.sv
// Randomized scoreboard bench: a 16-deep FWFT instance and a 5-deep
// registered-read instance driven side by side against a queue model.
module tb_sync_trace_fifo;

    logic        clk;
    logic        rst_n;
    logic [15:0] din   [2];
    logic        wr    [2];
    logic        rd    [2];
    logic        full  [2];
    logic        empty [2];
    logic [15:0] dout  [2];
    logic        pfull [2];
    logic        pempty[2];
    logic        ovf   [2];
    logic        unf   [2];
    logic [4:0]  cnt0;
    logic [3:0]  cnt1;

    int checks   = 0;
    int failures = 0;

    // reference model state
    logic [15:0] sbq [2][$];
    int          mcnt    [2];
    logic        nxt_ovf [2];
    logic        nxt_unf [2];
    int          cur_cnt [2];
    logic        cur_ovf [2];
    logic        cur_unf [2];
    logic        mon_en;
    logic        pend1;
    logic [15:0] pend_val1;
    logic [15:0] hold1;

    sync_trace_fifo #(.DEPTH(16), .WIDTH(16), .FWFT(1)) u_fwft (
        .clk(clk), .rst_n(rst_n), .din(din[0]), .write(wr[0]), .full(full[0]),
        .dout(dout[0]), .read(rd[0]), .empty(empty[0]), .data_count(cnt0),
        .prog_full(pfull[0]), .prog_empty(pempty[0]),
        .overflow(ovf[0]), .underflow(unf[0])
    );

    sync_trace_fifo #(.DEPTH(5), .WIDTH(16), .FWFT(0), .PROG_FULL_THRESH(4),
                      .PROG_EMPTY_THRESH(1), .DOUT_RESET_VALUE(16'hBEEF)) u_std (
        .clk(clk), .rst_n(rst_n), .din(din[1]), .write(wr[1]), .full(full[1]),
        .dout(dout[1]), .read(rd[1]), .empty(empty[1]), .data_count(cnt1),
        .prog_full(pfull[1]), .prog_empty(pempty[1]),
        .overflow(ovf[1]), .underflow(unf[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int dep(int k);
        return (k == 0) ? 16 : 5;
    endfunction
    function automatic int pf_lvl(int k);
        return (k == 0) ? 14 : 4;
    endfunction
    function automatic int pe_lvl(int k);
        return (k == 0) ? 2 : 1;
    endfunction
    function automatic logic [15:0] rst_val(int k);
        return (k == 0) ? 16'h0000 : 16'hBEEF;
    endfunction
    function automatic logic [31:0] cnt_of(int k);
        return (k == 0) ? 32'(cnt0) : 32'(cnt1);
    endfunction

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s inst=%0d t=%0t got=%0h expected=%0h", name, k, $time, act, exp);
        end
    endtask

    task automatic chk_reset();
        for (int k = 0; k < 2; k++) begin
            chk("rst_count", k, cnt_of(k), 32'd0);
            chk("rst_empty", k, 32'(empty[k]), 32'd1);
            chk("rst_full", k, 32'(full[k]), 32'd0);
            chk("rst_prog_empty", k, 32'(pempty[k]), 32'd1);
            chk("rst_prog_full", k, 32'(pfull[k]), 32'd0);
            chk("rst_overflow", k, 32'(ovf[k]), 32'd0);
            chk("rst_underflow", k, 32'(unf[k]), 32'd0);
            chk("rst_dout", k, 32'(dout[k]), 32'(rst_val(k)));
        end
    endtask

    task automatic clear_model();
        for (int k = 0; k < 2; k++) begin
            sbq[k].delete();
            mcnt[k]    = 0;
            nxt_ovf[k] = 1'b0;
            nxt_unf[k] = 1'b0;
        end
        pend1 = 1'b0;
        hold1 = 16'hBEEF;
    endtask

    // One cycle of stimulus: pw/pr are write/read probabilities in percent.
    task automatic issue(input int pw, input int pr);
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            logic        w;
            logic        r;
            logic [15:0] d;
            logic        wacc;
            logic        racc;
            cur_cnt[k] = mcnt[k];
            cur_ovf[k] = nxt_ovf[k];
            cur_unf[k] = nxt_unf[k];
            w = ($urandom_range(99) < pw);
            r = ($urandom_range(99) < pr);
            d = 16'($urandom);
            wr[k] = w;
            rd[k] = r;
            din[k] = d;
            wacc = w && (mcnt[k] < dep(k));
            racc = r && (mcnt[k] > 0);
            if (wacc) sbq[k].push_back(d);
            mcnt[k] = mcnt[k] + (wacc ? 1 : 0) - (racc ? 1 : 0);
            nxt_ovf[k] = w && !wacc;
            nxt_unf[k] = r && !racc;
        end
        mon_en = 1'b1;
    endtask

    task automatic run(input int n, input int pw, input int pr);
        for (int i = 0; i < n; i++) issue(pw, pr);
    endtask

    // Reset asserted between edges, with writes held high to prove they are ignored.
    task automatic mid_reset();
        @(posedge clk);
        #1;
        mon_en = 1'b0;
        rst_n  = 1'b0;
        for (int k = 0; k < 2; k++) begin
            wr[k]  = 1'b1;
            rd[k]  = 1'b0;
            din[k] = 16'h5A5A;
        end
        clear_model();
        #1;
        chk_reset();
        @(posedge clk);
        #1;
        chk_reset();
        @(negedge clk);
        for (int k = 0; k < 2; k++) wr[k] = 1'b0;
        rst_n = 1'b1;
    endtask

    // Monitor: flag checks every cycle, data checks whenever a word leaves the FIFO.
    always @(negedge clk) begin
        if (mon_en) begin
            for (int k = 0; k < 2; k++) begin
                chk("count", k, cnt_of(k), 32'(cur_cnt[k]));
                chk("full", k, 32'(full[k]), 32'(cur_cnt[k] == dep(k)));
                chk("empty", k, 32'(empty[k]), 32'(cur_cnt[k] == 0));
                chk("prog_full", k, 32'(pfull[k]), 32'(cur_cnt[k] >= pf_lvl(k)));
                chk("prog_empty", k, 32'(pempty[k]), 32'(cur_cnt[k] <= pe_lvl(k)));
                chk("overflow", k, 32'(ovf[k]), 32'(cur_ovf[k]));
                chk("underflow", k, 32'(unf[k]), 32'(cur_unf[k]));
            end
            if (rd[0] && !empty[0]) begin
                checks++;
                if (sbq[0].size() == 0) begin
                    failures++;
                    $display("FAIL pop_no_data inst=0 t=%0t got=%0h expected=none", $time, dout[0]);
                end else begin
                    logic [15:0] e0;
                    e0 = sbq[0].pop_front();
                    if (dout[0] !== e0) begin
                        failures++;
                        $display("FAIL dout_fwft inst=0 t=%0t got=%0h expected=%0h", $time, dout[0], e0);
                    end
                end
            end
            if (pend1) begin
                chk("dout_reg", 1, 32'(dout[1]), 32'(pend_val1));
                hold1 = pend_val1;
            end else begin
                chk("dout_hold", 1, 32'(dout[1]), 32'(hold1));
            end
            pend1 = 1'b0;
            if (rd[1] && !empty[1]) begin
                checks++;
                if (sbq[1].size() == 0) begin
                    failures++;
                    $display("FAIL pop_no_data inst=1 t=%0t got=%0h expected=none", $time, dout[1]);
                end else begin
                    pend_val1 = sbq[1].pop_front();
                    pend1     = 1'b1;
                end
            end
        end
    end

    initial begin
        mon_en = 1'b0;
        rst_n  = 1'b0;
        for (int k = 0; k < 2; k++) begin
            wr[k]  = 1'b0;
            rd[k]  = 1'b0;
            din[k] = 16'h0000;
        end
        clear_model();
        repeat (2) @(posedge clk);
        #1;
        chk_reset();
        @(negedge clk);
        rst_n = 1'b1;

        run(20, 100, 0);     // fill past full, overflow pulses
        run(20, 0, 100);     // drain past empty, underflow pulses
        run(1, 100, 100);    // read+write at empty
        run(2, 0, 100);
        run(5, 100, 0);      // count 5
        run(10, 100, 100);   // steady read+write
        run(20, 0, 100);
        run(200, 50, 50);
        run(200, 70, 40);
        run(200, 30, 70);
        run(20, 0, 100);
        run(7, 100, 0);      // mid-stream occupancy before reset
        mid_reset();
        run(1, 100, 0);
        run(2, 0, 100);
        run(40, 60, 60);
        run(3, 0, 0);
        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
